// File: rtl/mem_responder_if.sv
// Load/store handshake bundle between a requester and mem_responder.
// Latency: n/a (wires only).
// Backpressure: requester owns mem_start; the responder answers with busy/done.
//
// Signals
//   mem_start  request strobe          mem_out   load result
//   mem_adr    byte address            mem_busy  request in flight
//   mem_we     1=store, 0=load         mem_done  one-cycle completion pulse
//   mem_siz    RV32I funct3 size code  mem_err   misalignment flag (with done)
//   mem_in     store data
// Modports: master drives the request side, slave drives the response side.
interface mem_responder_if;
    logic        mem_start;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [2:0]  mem_siz;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    modport master (
        output mem_start, mem_adr, mem_we, mem_siz, mem_in,
        input  mem_out, mem_busy, mem_done, mem_err
    );

    modport slave (
        input  mem_start, mem_adr, mem_we, mem_siz, mem_in,
        output mem_out, mem_busy, mem_done, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed little-endian data store answering RV32I-style loads/stores.
// Latency: busy for LATENCY cycles after accept, then a one-cycle done pulse.
// Backpressure: none queued; starts seen while a request is in flight are dropped.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (storage contents are kept)
//   bus  mem_responder_if.slave: start/adr/we/siz/in -> busy/done/out/err
// Parameters: ADDR_W (store depth 2**ADDR_W bytes), LATENCY (>=1),
//   INIT_FILE (image name; accepted, contents start unknown).
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned H/W accesses
//   (they then complete with mem_err=1, mem_out=0 and write nothing).
module mem_responder #(
    parameter int    ADDR_W    = 16,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                armed;
    logic [ADDR_W-1:0]   adr_q;
    logic                we_q;
    logic [2:0]          siz_q;
    logic [31:0]         wdata_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         out_q;
    logic                err_q;

    logic [7:0]          mem [DEPTH];

    logic unused_init;
    assign unused_init = (INIT_FILE != "");

    // Upper address bits are outside the store and deliberately ignored.
    logic unused_adr_hi;
    assign unused_adr_hi = ^bus.mem_adr[31:ADDR_W];

    // Byte lanes, each wrapping modulo the store size.
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    assign a0 = adr_q;
    assign a1 = adr_q + ADDR_W'(1);
    assign a2 = adr_q + ADDR_W'(2);
    assign a3 = adr_q + ADDR_W'(3);

    // funct3[1:0] selects width; 011/110/111 fall through to word.
    logic is_b, is_h, is_w;
    assign is_b = (siz_q[1:0] == 2'b00);
    assign is_h = (siz_q[1:0] == 2'b01);
    assign is_w = !is_b && !is_h;

    logic misalign;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_h && adr_q[0]) || (is_w && (adr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    logic [31:0] rd_word;
    assign rd_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

    logic [31:0] ld_data;
    always_comb begin
        ld_data = rd_word;
        case (siz_q)
            3'b000:  ld_data = {{24{rd_word[7]}},  rd_word[7:0]};
            3'b100:  ld_data = {24'h0,             rd_word[7:0]};
            3'b001:  ld_data = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b101:  ld_data = {16'h0,             rd_word[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    // The last WAIT cycle is where the request completes; the edge that
    // leaves it enters RESP and commits any store. rst gates the write so
    // a reset landing on that edge aborts cleanly.
    logic commit;
    logic wr_en;
    assign commit = (state == S_WAIT) && (cnt == CNT_LAST);
    assign wr_en  = commit && we_q && !misalign && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[a0] <= wdata_q[7:0];
            if (!is_b) begin
                mem[a1] <= wdata_q[15:8];
            end
            if (is_w) begin
                mem[a2] <= wdata_q[23:16];
                mem[a3] <= wdata_q[31:24];
            end
        end
    end

    // armed stays low for the first edge after reset release so a start
    // held across the release is not taken on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            armed   <= 1'b0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            siz_q   <= 3'b000;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            armed  <= 1'b1;
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (bus.mem_start && armed) begin
                        adr_q   <= bus.mem_adr[ADDR_W-1:0];
                        we_q    <= bus.mem_we;
                        siz_q   <= bus.mem_siz;
                        wdata_q <= bus.mem_in;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_WAIT;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= misalign;
                        out_q  <= (we_q || misalign) ? 32'h0 : ld_data;
                        state  <= S_RESP;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_busy = busy_q;
    assign bus.mem_done = done_q;
    assign bus.mem_out  = out_q;
    assign bus.mem_err  = err_q;

endmodule
